// File: rtl/ysyx_23060221_ifu_if.sv
// Fetch-side bus bundle for the IFU: memory read-address/read-data channels,
// the decode handshake, the next-PC report and the fault/status outputs.
interface ysyx_23060221_ifu_if;
  // Memory read-address channel
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  // Memory read-data channel
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_err;
  // Decode handshake
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        IFU_valid;
  logic        IDU_ready;
  // Next-PC report from execute/writeback
  logic        npc_valid;
  logic [31:0] npc;
  // Status
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_cnt;

  modport master (
    output ar_valid, ar_addr, r_ready, inst, pc_out, IFU_valid,
           fault, fault_cause, fetch_cnt,
    input  ar_ready, r_valid, r_data, r_err, IDU_ready, npc_valid, npc
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, inst, pc_out, IFU_valid,
           fault, fault_cause, fetch_cnt,
    output ar_ready, r_valid, r_data, r_err, IDU_ready, npc_valid, npc
  );
endinterface

// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit for the multi-cycle NPC core. Holds the PC, issues
// one instruction fetch per turn, hands the word to decode and then waits for
// the next-PC report. Bus errors and misaligned next PCs park it in FAULT.
module ysyx_23060221_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_23060221_ifu_if.master      bus
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT   = 3'd2,
    S_NEXT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_ACCESS = 2'b01;
  localparam logic [1:0] CAUSE_MISAL  = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        npc_pend_q, npc_pend_d;
  logic [31:0] npc_buf_q, npc_buf_d;

  // Instructions are word aligned; any low address bit set is a fault.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // State and datapath registers; reset returns everything to the boot values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      pc_out_q    <= 32'd0;
      fetch_cnt_q <= 32'd0;
      cause_q     <= CAUSE_NONE;
      npc_pend_q  <= 1'b0;
      npc_buf_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      fetch_cnt_q <= fetch_cnt_d;
      cause_q     <= cause_d;
      npc_pend_q  <= npc_pend_d;
      npc_buf_q   <= npc_buf_d;
    end
  end

  // Next-state logic; a buffered next PC wins over one arriving the same cycle.
  always_comb begin
    logic [31:0] next_pc;
    logic        apply;
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    fetch_cnt_d = fetch_cnt_q;
    cause_d     = cause_q;
    npc_pend_d  = npc_pend_q;
    npc_buf_d   = npc_buf_q;
    next_pc     = bus.npc;
    apply       = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.ar_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.r_valid) begin
          if (bus.r_err) begin
            cause_d = CAUSE_ACCESS;
            state_d = S_FAULT;
          end else begin
            inst_d   = bus.r_data;
            pc_out_d = pc_q;
            state_d  = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (bus.IDU_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          if (npc_pend_q) begin
            next_pc = npc_buf_q;
            apply   = 1'b1;
          end else if (bus.npc_valid) begin
            apply   = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end else if (bus.npc_valid && !npc_pend_q) begin
          // Early report: hold it until decode takes the instruction.
          npc_pend_d = 1'b1;
          npc_buf_d  = bus.npc;
        end
      end
      S_NEXT: begin
        if (bus.npc_valid) apply = 1'b1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (apply) begin
      if (is_misaligned(next_pc)) begin
        cause_d = CAUSE_MISAL;
        state_d = S_FAULT;
      end else begin
        pc_d       = next_pc;
        npc_pend_d = 1'b0;
        state_d    = S_FETCH;
      end
    end
  end

  // Outputs are pure functions of registered state.
  assign bus.ar_valid    = (state_q == S_FETCH);
  assign bus.ar_addr     = pc_q;
  assign bus.r_ready     = (state_q == S_WAIT);
  assign bus.IFU_valid   = (state_q == S_OUT);
  assign bus.inst        = inst_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.fault       = (state_q == S_FAULT);
  assign bus.fault_cause = cause_q;
  assign bus.fetch_cnt   = fetch_cnt_q;

endmodule
